// File: rtl/fifo_serializer_if.sv
// ============================================================================
//  Module   : fifo_serializer_if
//  Purpose  : Bundles the FIFO drain side and the serial valid/ready link of
//             the word serializer.
//  Ports    : fifo_empty / fifo_data / fifo_deq  - show-ahead FIFO head + pop
//             tx_valid / tx_bit / tx_last / tx_ready - serial output link
//  Modports : master - the serializer (pops the FIFO, drives the link)
//             slave  - the environment (FIFO + serial transmitter)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_serializer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_deq;
   logic                  tx_valid;
   logic                  tx_bit;
   logic                  tx_last;
   logic                  tx_ready;

   modport master (
      input  fifo_empty, fifo_data, tx_ready,
      output fifo_deq, tx_valid, tx_bit, tx_last
   );

   modport slave (
      output fifo_empty, fifo_data, tx_ready,
      input  fifo_deq, tx_valid, tx_bit, tx_last
   );
endinterface

`default_nettype wire

// File: rtl/fifo_serializer.sv
// ============================================================================
//  Module   : fifo_serializer
//  Purpose  : Pops parallel words from a show-ahead FIFO and shifts them out
//             bit-serially over a valid/ready link, streaming consecutive
//             words with no idle cycle between frames.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - fifo_serializer_if.master (FIFO pop side + serial link)
//             busy - a word frame is in progress
//  Macro    : SERIALIZER_PARITY_EN - appends one even-parity bit per word,
//             which then carries tx_last instead of the final data bit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   fifo_serializer_if.master  bus,
   output logic               busy
);

   localparam int              CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
`endif

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_shifted;
   logic [CNT_W-1:0]      cnt;
   logic                  out_bit;
   logic                  term;
   logic                  deq_raw;
   logic                  deq;
   logic                  advance;
`ifdef SERIALIZER_PARITY_EN
   logic                  parity;
`endif

   // Output end of the shift register and the matching shift direction.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign out_bit       = shreg[DATA_WIDTH-1];
         assign shreg_shifted = {shreg[DATA_WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign out_bit       = shreg[0];
         assign shreg_shifted = {1'b0, shreg[DATA_WIDTH-1:1]};
      end
   endgenerate

   assign term = (cnt == LAST_CNT);

   // Next state and pop decision. A pop always coincides with a load of
   // the shift register, so one strobe serves both.
   always_comb begin
      state_nxt = state;
      deq_raw   = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.fifo_empty) begin
               deq_raw   = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.tx_ready) begin
               if (!term) begin
                  advance = 1'b1;
               end else begin
`ifdef SERIALIZER_PARITY_EN
                  state_nxt = PARITY;
`else
                  // Reload on the final handshake for gap-free streaming.
                  if (!bus.fifo_empty) begin
                     deq_raw = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
`endif
               end
            end
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: begin
            if (bus.tx_ready) begin
               if (!bus.fifo_empty) begin
                  deq_raw   = 1'b1;
                  state_nxt = SHIFT;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Reset wins over any pop in the same cycle, so no word is lost to a
   // pop whose load would be discarded.
   assign deq          = deq_raw & ~rst;
   assign bus.fifo_deq = deq;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
`ifdef SERIALIZER_PARITY_EN
         parity <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (deq) begin
            shreg <= bus.fifo_data;
            cnt   <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity <= ^bus.fifo_data;
`endif
         end else if (advance) begin
            shreg <= shreg_shifted;
            cnt   <= cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      bus.tx_bit  = 1'b0;
      bus.tx_last = 1'b0;
      case (state)
         SHIFT: begin
            bus.tx_bit = out_bit;
`ifndef SERIALIZER_PARITY_EN
            bus.tx_last = term;
`endif
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: begin
            bus.tx_bit  = parity;
            bus.tx_last = 1'b1;
         end
`endif
         default: begin
            bus.tx_bit  = 1'b0;
            bus.tx_last = 1'b0;
         end
      endcase
   end

   assign bus.tx_valid = (state != IDLE);
   assign busy         = (state != IDLE);

endmodule

`default_nettype wire
